// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Inserts LOAD_LAT bubbles per hazard and counts them in a saturating counter.
module id_ex_stage #(
   parameter logic [5:0] LOAD_OPCODE = 6'b010000,
   parameter int         LOAD_LAT    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [5:0]  id_opcode,
   input  logic [4:0]  id_rd,
   input  logic [4:0]  id_rn,
   input  logic [4:0]  id_rm,
   input  logic [9:0]  id_imm10,
   input  logic [14:0] id_imm15,
   input  logic [19:0] id_imm20,
   input  logic [15:0] id_pc,
   input  logic        flush,
   input  logic        stall_ext,
   output logic        ex_valid,
   output logic [5:0]  ex_opcode,
   output logic [4:0]  ex_rd,
   output logic [4:0]  ex_rn,
   output logic [4:0]  ex_rm,
   output logic [9:0]  ex_imm10,
   output logic [14:0] ex_imm15,
   output logic [19:0] ex_imm20,
   output logic [15:0] ex_pc,
   output logic        stall_out,
   output logic [15:0] bubble_cnt
);

   typedef enum logic {RUN, HSTALL} state_t;

   state_t     state, state_nxt;
   logic [1:0] rem, rem_nxt;
   logic       hazard;
   logic       bubble;
   logic       kill;
   logic       load_id;

   // A bubble leaves ex_valid low, so it can never look like a load in EX.
   assign hazard = id_valid & ex_valid & (ex_opcode == LOAD_OPCODE) & (ex_rd != 5'd0)
                 & ((ex_rd == id_rn) | (ex_rd == id_rm));

   assign stall_out = stall_ext
                    | (~rst & ~flush & (((state == RUN) & hazard) | (state == HSTALL)));

   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      bubble    = 1'b0;
      kill      = 1'b0;
      load_id   = 1'b0;
      if (flush) begin
         state_nxt = RUN;
         rem_nxt   = 2'd0;
         kill      = 1'b1;
      end else if (stall_ext) begin
         state_nxt = state;
      end else if (state == HSTALL) begin
         bubble  = 1'b1;
         rem_nxt = rem - 2'd1;
         if (rem == 2'd1) begin
            state_nxt = RUN;
         end
      end else if (hazard) begin
         bubble = 1'b1;
         if (LOAD_LAT > 1) begin
            state_nxt = HSTALL;
            rem_nxt   = 2'(LOAD_LAT - 1);
         end
      end else begin
         load_id = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         rem   <= 2'd0;
      end else begin
         state <= state_nxt;
         rem   <= rem_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid  <= 1'b0;
         ex_opcode <= '0;
         ex_rd     <= '0;
         ex_rn     <= '0;
         ex_rm     <= '0;
         ex_imm10  <= '0;
         ex_imm15  <= '0;
         ex_imm20  <= '0;
         ex_pc     <= '0;
      end else if (kill || bubble) begin
         ex_valid <= 1'b0;
      end else if (load_id) begin
         ex_valid  <= id_valid;
         ex_opcode <= id_opcode;
         ex_rd     <= id_rd;
         ex_rn     <= id_rn;
         ex_rm     <= id_rm;
         ex_imm10  <= id_imm10;
         ex_imm15  <= id_imm15;
         ex_imm20  <= id_imm20;
         ex_pc     <= id_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt <= 16'd0;
      end else if (bubble && (bubble_cnt != 16'hFFFF)) begin
         bubble_cnt <= bubble_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (LOAD_LAT=1 and 3) driven in parallel
// and compared each cycle against a bubble-queue reference model.
module tb_id_ex_stage;

   localparam logic [5:0] LOAD_OP = 6'b010000;

   typedef struct packed {
      logic        valid;
      logic [5:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rn;
      logic [4:0]  rm;
      logic [9:0]  i10;
      logic [14:0] i15;
      logic [19:0] i20;
      logic [15:0] pc;
   } instr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, id_valid, flush, stall_ext;
   logic [5:0]  id_opcode;
   logic [4:0]  id_rd, id_rn, id_rm;
   logic [9:0]  id_imm10;
   logic [14:0] id_imm15;
   logic [19:0] id_imm20;
   logic [15:0] id_pc;

   logic        ex_valid   [2];
   logic [5:0]  ex_opcode  [2];
   logic [4:0]  ex_rd      [2];
   logic [4:0]  ex_rn      [2];
   logic [4:0]  ex_rm      [2];
   logic [9:0]  ex_imm10   [2];
   logic [14:0] ex_imm15   [2];
   logic [19:0] ex_imm20   [2];
   logic [15:0] ex_pc      [2];
   logic        stall_out  [2];
   logic [15:0] bubble_cnt [2];

   id_ex_stage #(.LOAD_OPCODE(LOAD_OP), .LOAD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rd(id_rd), .id_rn(id_rn), .id_rm(id_rm), .id_imm10(id_imm10),
      .id_imm15(id_imm15), .id_imm20(id_imm20), .id_pc(id_pc), .flush(flush),
      .stall_ext(stall_ext), .ex_valid(ex_valid[0]), .ex_opcode(ex_opcode[0]),
      .ex_rd(ex_rd[0]), .ex_rn(ex_rn[0]), .ex_rm(ex_rm[0]), .ex_imm10(ex_imm10[0]),
      .ex_imm15(ex_imm15[0]), .ex_imm20(ex_imm20[0]), .ex_pc(ex_pc[0]),
      .stall_out(stall_out[0]), .bubble_cnt(bubble_cnt[0]));

   id_ex_stage #(.LOAD_OPCODE(LOAD_OP), .LOAD_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rd(id_rd), .id_rn(id_rn), .id_rm(id_rm), .id_imm10(id_imm10),
      .id_imm15(id_imm15), .id_imm20(id_imm20), .id_pc(id_pc), .flush(flush),
      .stall_ext(stall_ext), .ex_valid(ex_valid[1]), .ex_opcode(ex_opcode[1]),
      .ex_rd(ex_rd[1]), .ex_rn(ex_rn[1]), .ex_rm(ex_rm[1]), .ex_imm10(ex_imm10[1]),
      .ex_imm15(ex_imm15[1]), .ex_imm20(ex_imm20[1]), .ex_pc(ex_pc[1]),
      .stall_out(stall_out[1]), .bubble_cnt(bubble_cnt[1]));

   // Model: the EX slot contents, bubbles still owed, and total bubbles seen.
   int     lat [2] = '{1, 3};
   instr_t mEx [2];
   int     mLeft [2];
   int     mCnt [2];
   int     compared = 0;
   int     mismatched = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic modelHazard(int k);
      return id_valid && mEx[k].valid && (mEx[k].op == LOAD_OP) && (mEx[k].rd != 5'd0)
             && ((mEx[k].rd == id_rn) || (mEx[k].rd == id_rm));
   endfunction

   function automatic logic modelStall(int k);
      return stall_ext || (!rst && !flush && ((mLeft[k] > 0) || modelHazard(k)));
   endfunction

   task automatic modelEdge(input int k, input logic haz);
      if (rst) begin
         mEx[k] = '0;
         mLeft[k] = 0;
         mCnt[k] = 0;
      end else if (flush) begin
         mEx[k].valid = 1'b0;
         mLeft[k] = 0;
      end else if (stall_ext) begin
         mLeft[k] = mLeft[k];
      end else if (mLeft[k] > 0 || haz) begin
         mEx[k].valid = 1'b0;
         mLeft[k] = (mLeft[k] > 0) ? mLeft[k] - 1 : lat[k] - 1;
         mCnt[k] = (mCnt[k] < 65535) ? mCnt[k] + 1 : 65535;
      end else begin
         mEx[k] = '{id_valid, id_opcode, id_rd, id_rn, id_rm, id_imm10, id_imm15, id_imm20, id_pc};
      end
   endtask

   task automatic checkAll();
      for (int k = 0; k < 2; k++) begin
         checkOutput($sformatf("ex_valid L%0d", lat[k]), 32'(ex_valid[k]), 32'(mEx[k].valid));
         checkOutput($sformatf("bubble_cnt L%0d", lat[k]), 32'(bubble_cnt[k]), 32'(mCnt[k]));
         if (mEx[k].valid) begin
            checkOutput($sformatf("ex_opcode L%0d", lat[k]), 32'(ex_opcode[k]), 32'(mEx[k].op));
            checkOutput($sformatf("ex_rd L%0d", lat[k]), 32'(ex_rd[k]), 32'(mEx[k].rd));
            checkOutput($sformatf("ex_rn L%0d", lat[k]), 32'(ex_rn[k]), 32'(mEx[k].rn));
            checkOutput($sformatf("ex_rm L%0d", lat[k]), 32'(ex_rm[k]), 32'(mEx[k].rm));
            checkOutput($sformatf("ex_imm10 L%0d", lat[k]), 32'(ex_imm10[k]), 32'(mEx[k].i10));
            checkOutput($sformatf("ex_imm15 L%0d", lat[k]), 32'(ex_imm15[k]), 32'(mEx[k].i15));
            checkOutput($sformatf("ex_imm20 L%0d", lat[k]), 32'(ex_imm20[k]), 32'(mEx[k].i20));
            checkOutput($sformatf("ex_pc L%0d", lat[k]), 32'(ex_pc[k]), 32'(mEx[k].pc));
         end
      end
   endtask

   task automatic setId(input logic v, input logic [5:0] op, input logic [4:0] rd,
                        input logic [4:0] rn, input logic [4:0] rm);
      id_valid  = v;
      id_opcode = op;
      id_rd     = rd;
      id_rn     = rn;
      id_rm     = rm;
      id_imm10  = 10'($urandom);
      id_imm15  = 15'($urandom);
      id_imm20  = 20'($urandom);
      id_pc     = 16'($urandom);
   endtask

   // One clock: drive controls, check the combinational stall, clock, check registers.
   task automatic applyStimulus(input logic r, input logic f, input logic s, input bit doCheck);
      logic haz [2];
      rst = r;
      flush = f;
      stall_ext = s;
      #1;
      for (int k = 0; k < 2; k++) begin
         haz[k] = modelHazard(k);
         if (doCheck) checkOutput($sformatf("stall_out L%0d", lat[k]), 32'(stall_out[k]), 32'(modelStall(k)));
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) modelEdge(k, haz[k]);
      #1;
      if (doCheck) checkAll();
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         mEx[k] = '0;
         mLeft[k] = 0;
         mCnt[k] = 0;
      end
      setId(1'b1, 6'h3F, 5'd9, 5'd9, 5'd9);
      rst = 1'b1;
      flush = 1'b0;
      stall_ext = 1'b0;
      @(posedge clk);
      #1;
      doReset();
      for (int k = 0; k < 2; k++) begin
         checkOutput("rst ex_opcode", 32'(ex_opcode[k]), 32'h0);
         checkOutput("rst ex_rd", 32'(ex_rd[k]), 32'h0);
         checkOutput("rst ex_pc", 32'(ex_pc[k]), 32'h0);
         checkOutput("rst ex_imm20", 32'(ex_imm20[k]), 32'h0);
      end

      // Pass-through of a plain instruction
      setId(1'b1, 6'h05, 5'd3, 5'd1, 5'd2);
      id_pc = 16'h0004;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("pass ex_valid", 32'(ex_valid[0]), 32'h1);
      checkOutput("pass ex_opcode", 32'(ex_opcode[0]), 32'h05);
      checkOutput("pass ex_rd", 32'(ex_rd[0]), 32'h3);
      checkOutput("pass ex_pc", 32'(ex_pc[0]), 32'h0004);

      // Load-use: dependent instruction held behind a load to r5
      doReset();
      setId(1'b1, LOAD_OP, 5'd5, 5'd1, 5'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      setId(1'b1, 6'h01, 5'd7, 5'd5, 5'd0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("lu bubbles L1", 32'(bubble_cnt[0]), 32'd1);
      checkOutput("lu bubbles L3", 32'(bubble_cnt[1]), 32'd3);
      checkOutput("lu dep in EX L3", 32'(ex_rd[1]), 32'd7);

      // Flush on the third stall cycle of a three-bubble hazard
      doReset();
      setId(1'b1, LOAD_OP, 5'd5, 5'd1, 5'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      setId(1'b1, 6'h01, 5'd7, 5'd0, 5'd5);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("flush bubbles L3", 32'(bubble_cnt[1]), 32'd2);
      checkOutput("flush ex_valid L3", 32'(ex_valid[1]), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      // External hold keeps EX contents
      doReset();
      setId(1'b1, 6'h0A, 5'd4, 5'd1, 5'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      setId(1'b1, 6'h0B, 5'd6, 5'd3, 5'd3);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("hold ex_opcode", 32'(ex_opcode[0]), 32'h0A);
      checkOutput("hold ex_rd", 32'(ex_rd[1]), 32'h4);

      // r0 load never stalls its consumer
      doReset();
      setId(1'b1, LOAD_OP, 5'd0, 5'd1, 5'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      setId(1'b1, 6'h01, 5'd3, 5'd0, 5'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("r0 bubbles", 32'(bubble_cnt[1]), 32'd0);

      // Randomized traffic with a small register set to provoke hazards
      doReset();
      for (int i = 0; i < 800; i++) begin
         setId(1'($urandom_range(0, 3) != 0),
               ($urandom_range(0, 9) < 4) ? LOAD_OP : 6'($urandom),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         applyStimulus(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 8),
                       1'($urandom_range(0, 99) < 12), 1'b1);
      end

      // Self-dependent load repeated until the LOAD_LAT=3 counter saturates
      doReset();
      setId(1'b1, LOAD_OP, 5'd5, 5'd5, 5'd0);
      for (int i = 0; i < 87500; i++) applyStimulus(1'b0, 1'b0, 1'b0, (i >= 87490));
      checkOutput("saturate L3", 32'(bubble_cnt[1]), 32'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
